// File: rtl/state_pkg.sv
// Shared definitions for the mode sequencer: board defaults, the step request
// type and a width helper that never returns zero.
package state_pkg;

    localparam int unsigned BOARD_CLK_HZ        = 50_000_000;
    // 10 ms of stable key level at the board clock
    localparam int unsigned DEBOUNCE_DEFAULT    = BOARD_CLK_HZ / 100;
    // one auto-advance step per second at the board clock
    localparam int unsigned AUTO_PERIOD_DEFAULT = BOARD_CLK_HZ;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        FWD  = 2'd1,
        BACK = 2'd2
    } step_e;

    // Counter/index width for a value range of n, at least one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/state_seq_key_debounce.sv
// Raw active-low push-button conditioner.
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   key_n    - raw asynchronous key, low = pressed
//   level    - accepted (debounced) key level, 1 = released
//   press    - one-cycle pulse on each accepted 1->0 transition
module key_debounce
    import state_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int unsigned   CW       = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    // State registers; everything idles in the released state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    // Synchronise, count disagreement cycles, accept after a stable run.
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        // pulse only on the accepted falling edge (press), never on release
        press_d = level_q & ~level_d;
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/state_seq.sv
// Mode sequencer: two debounced keys step a wrap-around state index forward
// or backward; an optional timer auto-advances it.
//   MAX10_CLK1_50 - clock, rising edge
//   RESET_N       - asynchronous active-low reset
//   KEY_ADV_N     - raw key, low = pressed, steps forward
//   KEY_BACK_N    - raw key, low = pressed, steps backward
//   SW_AUTO       - level, enables auto-advance
//   SW_HOLD       - level, freezes the index
//   STATE_IDX     - current index 0..NUM_STATES-1
//   STATE_ONEHOT  - one-hot decode of STATE_IDX
//   STATE_CHG     - one-cycle strobe the cycle after an index change
//   WRAP          - coincident with STATE_CHG when the step wrapped
module state_seq
    import state_pkg::*;
#(
    parameter int unsigned NUM_STATES      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned AUTO_PERIOD     = AUTO_PERIOD_DEFAULT,
    localparam int unsigned IW             = clog2_min1(NUM_STATES)
) (
    input  logic                  MAX10_CLK1_50,
    input  logic                  RESET_N,
    input  logic                  KEY_ADV_N,
    input  logic                  KEY_BACK_N,
    input  logic                  SW_AUTO,
    input  logic                  SW_HOLD,
    output logic [IW-1:0]         STATE_IDX,
    output logic [NUM_STATES-1:0] STATE_ONEHOT,
    output logic                  STATE_CHG,
    output logic                  WRAP
);

    localparam int unsigned           TW         = clog2_min1(AUTO_PERIOD);
    localparam logic [TW-1:0]         TIMER_LAST = TW'(AUTO_PERIOD - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_STATES - 1);
    localparam logic [NUM_STATES-1:0] ONEHOT_0   = NUM_STATES'(1);

    logic adv_press, back_press;
    logic adv_level_unused, back_level_unused;

    logic                  auto_s1_q, auto_s1_d, auto_q, auto_d;
    logic                  hold_s1_q, hold_s1_d, hold_q, hold_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_STATES-1:0] onehot_q, onehot_d;
    logic                  stepped_q, stepped_d;
    logic                  wrapped_q, wrapped_d;
    logic                  chg_q, chg_d;
    logic                  wrap_q, wrap_d;

    logic  tick_c;
    logic  manual_c;
    step_e step_c;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_adv (
        .clk     (MAX10_CLK1_50),
        .reset_n (RESET_N),
        .key_n   (KEY_ADV_N),
        .level   (adv_level_unused),
        .press   (adv_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_back (
        .clk     (MAX10_CLK1_50),
        .reset_n (RESET_N),
        .key_n   (KEY_BACK_N),
        .level   (back_level_unused),
        .press   (back_press)
    );

    // State registers.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            auto_s1_q <= 1'b0;
            auto_q    <= 1'b0;
            hold_s1_q <= 1'b0;
            hold_q    <= 1'b0;
            timer_q   <= '0;
            idx_q     <= '0;
            onehot_q  <= ONEHOT_0;
            stepped_q <= 1'b0;
            wrapped_q <= 1'b0;
            chg_q     <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            auto_s1_q <= auto_s1_d;
            auto_q    <= auto_d;
            hold_s1_q <= hold_s1_d;
            hold_q    <= hold_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            onehot_q  <= onehot_d;
            stepped_q <= stepped_d;
            wrapped_q <= wrapped_d;
            chg_q     <= chg_d;
            wrap_q    <= wrap_d;
        end
    end

    // Switch synchronisers (switches are quasi-static, no debounce).
    always_comb begin
        auto_s1_d = SW_AUTO;
        auto_d    = auto_s1_q;
        hold_s1_d = SW_HOLD;
        hold_d    = hold_s1_q;
    end

    // Step arbitration: hold, then cancel, then manual, then auto.
    always_comb begin
        tick_c   = auto_q && !hold_q && (timer_q == TIMER_LAST);
        step_c   = NONE;
        manual_c = 1'b0;
        if (hold_q) begin
            step_c = NONE;
        end else if (adv_press && back_press) begin
            step_c = NONE;
        end else if (adv_press) begin
            step_c   = FWD;
            manual_c = 1'b1;
        end else if (back_press) begin
            step_c   = BACK;
            manual_c = 1'b1;
        end else if (tick_c) begin
            step_c = FWD;
        end
    end

    // Auto timer; a manual step restarts the period.
    always_comb begin
        timer_d = timer_q + TW'(1);
        if (!auto_q || hold_q || manual_c || (timer_q == TIMER_LAST)) begin
            timer_d = '0;
        end
    end

    // Index update with explicit wrap (N need not be a power of two).
    always_comb begin
        idx_d     = idx_q;
        wrapped_d = 1'b0;
        case (step_c)
            FWD: begin
                if (idx_q == IDX_LAST) begin
                    idx_d     = '0;
                    wrapped_d = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            BACK: begin
                if (idx_q == '0) begin
                    idx_d     = IDX_LAST;
                    wrapped_d = 1'b1;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            default: begin
                idx_d = idx_q;
            end
        endcase
        stepped_d = (step_c != NONE);
        onehot_d  = ONEHOT_0 << idx_d;
        // strobes trail the index register by one cycle
        chg_d     = stepped_q;
        wrap_d    = wrapped_q;
    end

    assign STATE_IDX    = idx_q;
    assign STATE_ONEHOT = onehot_q;
    assign STATE_CHG    = chg_q;
    assign WRAP         = wrap_q;

endmodule

// File: tb/tb_state_seq.sv
// Randomised scoreboard bench for state_seq (N=5, debounce 4, auto period 10).
module tb_state_seq;

    localparam int N = 5;
    localparam int D = 4;
    localparam int P = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_adv_n;
    logic       key_back_n;
    logic       sw_auto;
    logic       sw_hold;
    logic [2:0] state_idx;
    logic [4:0] state_onehot;
    logic       state_chg;
    logic       wrap;

    state_seq #(
        .NUM_STATES      (N),
        .DEBOUNCE_CYCLES (D),
        .AUTO_PERIOD     (P)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .RESET_N       (rst_n),
        .KEY_ADV_N     (key_adv_n),
        .KEY_BACK_N    (key_back_n),
        .SW_AUTO       (sw_auto),
        .SW_HOLD       (sw_hold),
        .STATE_IDX     (state_idx),
        .STATE_ONEHOT  (state_onehot),
        .STATE_CHG     (state_chg),
        .WRAP          (wrap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int idx;
        int wrp;
        int at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   model_idx;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: index arithmetic straight from the stepping rules.
    task automatic expect_step(input bit fwd, input int at);
        exp_t e;
        if (fwd) begin
            e.wrp = (model_idx == N - 1) ? 1 : 0;
            e.idx = (model_idx == N - 1) ? 0 : model_idx + 1;
        end else begin
            e.wrp = (model_idx == 0) ? 1 : 0;
            e.idx = (model_idx == 0) ? N - 1 : model_idx - 1;
        end
        e.at = at;
        sb.push_back(e);
        model_idx = e.idx;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the selected keys low for exactly len cycles, starting now.
    task automatic press(input bit adv, input bit back, input int len);
        if (adv)  key_adv_n  = 1'b0;
        if (back) key_back_n = 1'b0;
        step(len);
        key_adv_n  = 1'b1;
        key_back_n = 1'b1;
    endtask

    task automatic check_idx(input string name);
        check(name, int'(state_idx), model_idx);
        check({name, "_onehot"}, int'(state_onehot), 1 << model_idx);
    endtask

    // A clean press: change strobe lands 4+D cycles after the key goes low.
    task automatic clean_press(input bit fwd, input int len);
        expect_step(fwd, cyc + D + 4);
        press(fwd, !fwd, len);
        step(D + 10);
    endtask

    // Monitor: every change strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (state_chg) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_chg: got strobe idx=%0d wrap=%0d, expected none (cycle %0d)",
                             state_idx, wrap, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("chg_idx", int'(state_idx), mon_e.idx);
                    check("chg_onehot", int'(state_onehot), 1 << mon_e.idx);
                    check("chg_wrap", int'(wrap), mon_e.wrp);
                    check("chg_cycle", cyc, mon_e.at);
                end
            end else if (wrap) begin
                checks++;
                errors++;
                $display("FAIL wrap_without_chg: got wrap=1, expected 0 (cycle %0d)", cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    int a;
    int act;
    int len;
    bit dir;

    initial begin
        rst_n      = 1'b0;
        key_adv_n  = 1'b1;
        key_back_n = 1'b1;
        sw_auto    = 1'b0;
        sw_hold    = 1'b0;
        model_idx  = 0;

        // Reset for three cycles, then idle.
        @(posedge clk);
        #1;
        step(2);
        check_idx("rst_idx");
        check("rst_chg", int'(state_chg), 0);
        rst_n = 1'b1;
        step(20);
        check_idx("idle_idx");
        check("idle_chg", int'(state_chg), 0);
        check("idle_wrap", int'(wrap), 0);

        // Glitch shorter than the debounce window.
        press(1'b1, 1'b0, 3);
        step(D + 10);
        check_idx("glitch_idx");

        // Long clean press: exactly one step.
        clean_press(1'b1, 20);
        check_idx("long_press_idx");

        // Forward through the wrap back to 0.
        for (int k = 0; k < 4; k++) clean_press(1'b1, 6);
        check_idx("fwd_wrap_idx");

        // Back from 0 wraps to N-1.
        clean_press(1'b0, 6);
        check_idx("back_wrap_idx");

        // Both keys together cancel.
        press(1'b1, 1'b1, 8);
        step(D + 10);
        check_idx("both_idx");

        // Press during hold is discarded, not replayed afterwards.
        sw_hold = 1'b1;
        step(3);
        press(1'b1, 1'b0, 8);
        step(D + 10);
        sw_hold = 1'b0;
        step(20);
        check_idx("hold_idx");

        // Auto-advance: 55 cycles on gives 5 steps, 10 cycles apart.
        a = cyc;
        for (int k = 0; k < 5; k++) expect_step(1'b1, a + P + 3 + P * k);
        sw_auto = 1'b1;
        step(55);
        sw_auto = 1'b0;
        step(20);
        check_idx("auto_idx");

        // Manual back at cycle 25 of auto: it wins and restarts the period.
        a = cyc;
        expect_step(1'b1, a + 13);
        expect_step(1'b1, a + 23);
        expect_step(1'b0, a + 33);
        expect_step(1'b1, a + 43);
        sw_auto = 1'b1;
        step(25);
        press(1'b0, 1'b1, 8);
        step(12);
        sw_auto = 1'b0;
        step(20);
        check_idx("auto_manual_idx");

        // Randomised mix of presses, glitches, cancels and held presses.
        for (int it = 0; it < 40; it++) begin
            act = int'($urandom_range(0, 4));
            len = int'($urandom_range(D, D + 8));
            dir = 1'($urandom_range(0, 1));
            case (act)
                0, 1: clean_press(act == 0, len);
                2: begin
                    press(dir, !dir, int'($urandom_range(1, D - 1)));
                    step(D + 10);
                end
                3: begin
                    press(1'b1, 1'b1, len);
                    step(D + 10);
                end
                default: begin
                    sw_hold = 1'b1;
                    step(3);
                    press(dir, !dir, len);
                    step(D + 10);
                    sw_hold = 1'b0;
                    step(3);
                end
            endcase
        end
        check_idx("random_idx");

        // Asynchronous reset at idx 3 in the middle of a debounce.
        while (model_idx != 3) clean_press(1'b1, 6);
        check_idx("pre_reset_idx");
        key_adv_n = 1'b0;
        step(4);
        #2;
        rst_n     = 1'b0;
        key_adv_n = 1'b1;
        model_idx = 0;
        #1;
        check_idx("async_rst_idx");
        check("async_rst_chg", int'(state_chg), 0);
        step(2);
        rst_n = 1'b1;
        step(20);
        check_idx("post_reset_idx");

        // Drain: everything promised must have been observed.
        for (int w = 0; w < 50 && sb.size() != 0; w++) step(1);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
